// File: rtl/mem_bus_arb_pkg.sv
// Shared types and defaults for the fetch/data memory bus arbiter.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mem_bus_arb_timer.sv
// Grant watchdog: counts grant cycles without a slave ack.
module mem_bus_arb_timer
    import mem_bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the last permitted grant cycle so M_REQ is held TIMEOUT_CYC cycles.
    assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and data ports.
// Optional grant watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int AW          = 30,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic [DW-1:0] I_RDATA,
    output logic          I_ACK,
    output logic          I_ERR,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [3:0]    D_BE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WD,
    input  logic          D_INHIBIT,
    output logic [DW-1:0] D_RDATA,
    output logic          D_ACK,
    output logic          D_ERR,
    output logic          M_REQ,
    output logic          M_WE,
    output logic [3:0]    M_BE,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WD,
    input  logic [DW-1:0] M_RDATA,
    input  logic          M_ACK,
    input  logic          M_ERR,
    output logic          BUSY
);

    arb_state_t state, state_n;
    arb_owner_t owner, last;
    logic       err_q;
    logic       d_valid;
    logic       in_grant;
    logic       expire;

    assign d_valid  = D_REQ && !D_INHIBIT;
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);

`ifdef BUS_TIMEOUT_EN
    mem_bus_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr    (state == IDLE),
        .en     (in_grant && !M_ACK),
        .expire (expire)
    );
`else
    assign expire = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                // Data wins a tie unless it owned the bus last time.
                if (d_valid && (!I_REQ || last == OWN_I)) begin
                    state_n = GRANT_D;
                end else if (I_REQ) begin
                    state_n = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (M_ACK || expire) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner   <= OWN_I;
            last    <= OWN_I;
            err_q   <= 1'b0;
            M_WE    <= 1'b0;
            M_BE    <= 4'h0;
            M_ADDR  <= '0;
            M_WD    <= '0;
            I_RDATA <= '0;
            D_RDATA <= '0;
        end else begin
            if (state == IDLE && state_n == GRANT_D) begin
                owner  <= OWN_D;
                M_WE   <= D_WE;
                M_BE   <= D_BE;
                M_ADDR <= D_ADDR;
                M_WD   <= D_WD;
            end else if (state == IDLE && state_n == GRANT_I) begin
                owner  <= OWN_I;
                M_WE   <= 1'b0;
                M_BE   <= 4'hF;
                M_ADDR <= I_ADDR;
            end
            if (in_grant && M_ACK) begin
                err_q <= M_ERR;
                if (owner == OWN_I) begin
                    I_RDATA <= M_RDATA;
                end else begin
                    D_RDATA <= M_RDATA;
                end
            end else if (in_grant && expire) begin
                err_q <= 1'b1;
                if (owner == OWN_I) begin
                    I_RDATA <= '0;
                end else begin
                    D_RDATA <= '0;
                end
            end
            if (state == DONE) begin
                last <= owner;
            end
        end
    end

    assign M_REQ = in_grant;
    assign BUSY  = (state != IDLE);
    assign I_ACK = (state == DONE) && (owner == OWN_I);
    assign D_ACK = (state == DONE) && (owner == OWN_D);
    assign I_ERR = I_ACK && err_q;
    assign D_ERR = D_ACK && err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic [DW-1:0] I_RDATA;
    logic          I_ACK;
    logic          I_ERR;
    logic          D_REQ;
    logic          D_WE;
    logic [3:0]    D_BE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WD;
    logic          D_INHIBIT;
    logic [DW-1:0] D_RDATA;
    logic          D_ACK;
    logic          D_ERR;
    logic          M_REQ;
    logic          M_WE;
    logic [3:0]    M_BE;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WD;
    logic [DW-1:0] M_RDATA;
    logic          M_ACK;
    logic          M_ERR;
    logic          BUSY;

    mem_bus_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT_CYC(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA),
        .I_ACK(I_ACK), .I_ERR(I_ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR),
        .D_WD(D_WD), .D_INHIBIT(D_INHIBIT), .D_RDATA(D_RDATA),
        .D_ACK(D_ACK), .D_ERR(D_ERR),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_BE(M_BE), .M_ADDR(M_ADDR),
        .M_WD(M_WD), .M_RDATA(M_RDATA), .M_ACK(M_ACK), .M_ERR(M_ERR),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: who owned the bus last, and the last data each port received
    bit            last_d;
    logic [DW-1:0] mi_rdata;
    logic [DW-1:0] md_rdata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One arbitration round starting in an idle cycle; won: 0 none, 1 I, 2 D
    task automatic step(input int w, input bit e, input logic [DW-1:0] rd,
                        input bit spur, output int won);
        bit            iv, dv, wd;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [3:0]    ebe;
        logic [DW-1:0] ewd;
        iv = I_REQ;
        dv = D_REQ && !D_INHIBIT;
        chk("idle_busy", BUSY, 0);
        chk("idle_mreq", M_REQ, 0);
        M_ACK   = spur;
        M_ERR   = 1'($urandom);
        M_RDATA = $urandom;
        if (!iv && !dv) begin
            won = 0;
            tick();
            M_ACK = 0;
            M_ERR = 0;
            return;
        end
        wd  = dv && (!iv || !last_d);
        won = wd ? 2 : 1;
        ea  = wd ? D_ADDR : I_ADDR;
        ewe = wd ? D_WE : 1'b0;
        ebe = wd ? D_BE : 4'hF;
        ewd = D_WD;
        tick();
        M_ACK = 0;
        M_ERR = 0;
        for (int k = 0; k <= w; k++) begin
            chk("g_mreq", M_REQ, 1);
            chk("g_addr", M_ADDR, ea);
            chk("g_we", M_WE, ewe);
            chk("g_be", M_BE, ebe);
            if (wd) chk("g_wd", M_WD, ewd);
            chk("g_iack", I_ACK, 0);
            chk("g_dack", D_ACK, 0);
            if (wd) D_INHIBIT = 1;
            if (k == w) begin
                M_ACK   = 1;
                M_ERR   = e;
                M_RDATA = rd;
            end
            tick();
        end
        M_ACK = 0;
        M_ERR = 0;
        if (wd) md_rdata = rd;
        else    mi_rdata = rd;
        chk("d_mreq", M_REQ, 0);
        chk("d_busy", BUSY, 1);
        chk("d_iack", I_ACK, !wd);
        chk("d_dack", D_ACK, wd);
        chk("d_ierr", I_ERR, !wd && e);
        chk("d_derr", D_ERR, wd && e);
        chk("d_irdata", I_RDATA, mi_rdata);
        chk("d_drdata", D_RDATA, md_rdata);
        last_d = wd;
        tick();
        chk("post_iack", I_ACK, 0);
        chk("post_dack", D_ACK, 0);
    endtask

    int won;

    initial begin
        RESET = 1;
        I_REQ = 0; I_ADDR = '0;
        D_REQ = 0; D_WE = 0; D_BE = 0; D_ADDR = '0; D_WD = '0;
        D_INHIBIT = 0;
        M_RDATA = '0; M_ACK = 0; M_ERR = 0;
        last_d = 0; mi_rdata = '0; md_rdata = '0;
        #12;
        chk("rst_mreq", M_REQ, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_iack", I_ACK, 0);
        chk("rst_dack", D_ACK, 0);
        chk("rst_maddr", M_ADDR, 0);
        chk("rst_irdata", I_RDATA, 0);
        tick();
        RESET = 0;

        // fetch alone, zero-wait slave
        I_REQ = 1; I_ADDR = 30'h100;
        step(0, 0, 32'hDEADBEEF, 0, won);
        chk("fetch_won", won, 1);
        chk("fetch_rdata", I_RDATA, 32'hDEADBEEF);
        I_REQ = 0;

        // tie held for 8 transactions alternates starting with data
        I_REQ = 1; I_ADDR = 30'h2000;
        D_REQ = 1; D_WE = 0; D_BE = 4'hF; D_ADDR = 30'h3000;
        for (int k = 0; k < 8; k++) begin
            D_INHIBIT = 0;
            step(0, 0, $urandom, 0, won);
            chk("tie_order", won, (k % 2 == 0) ? 2 : 1);
        end
        I_REQ = 0; D_REQ = 0; D_INHIBIT = 0;

        // store with 5 wait states
        D_REQ = 1; D_WE = 1; D_BE = 4'b0011; D_WD = 32'h12345678;
        D_ADDR = 30'h0ABC;
        step(5, 0, 32'h0, 0, won);
        chk("store_won", won, 2);
        D_REQ = 0; D_WE = 0;

        // inhibited data request is not granted
        D_REQ = 1; D_INHIBIT = 1; D_ADDR = 30'h55;
        step(0, 0, 32'h1, 0, won);
        chk("inh_won", won, 0);
        step(0, 0, 32'h1, 1, won);
        chk("inh_won2", won, 0);
        D_INHIBIT = 0;
        step(1, 0, 32'hCAFEF00D, 0, won);
        chk("inh_rel_won", won, 2);
        D_REQ = 0; D_INHIBIT = 0;

        // fetch bus error
        I_REQ = 1; I_ADDR = 30'h777;
        step(2, 1, 32'hBAD0BAD0, 0, won);
        I_REQ = 0;

        // reset while granted to fetch
        I_REQ = 1; I_ADDR = 30'h999;
        tick();
        chk("rg_mreq", M_REQ, 1);
        #2 RESET = 1;
        #1;
        chk("rg_mreq_rst", M_REQ, 0);
        chk("rg_busy_rst", BUSY, 0);
        chk("rg_iack_rst", I_ACK, 0);
        tick();
        RESET = 0;
        I_REQ = 0;
        last_d = 0; mi_rdata = '0; md_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rg_noack", I_ACK, 0);
        end

        // after reset data wins the first tie again
        I_REQ = 1; D_REQ = 1; D_WE = 0; D_ADDR = 30'h42;
        step(0, 0, $urandom, 0, won);
        chk("rst_tie", won, 2);
        I_REQ = 0; D_REQ = 0;

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            if (!I_REQ || won == 1) begin
                I_REQ  = 1'($urandom);
                I_ADDR = 30'($urandom);
            end
            if (!D_REQ || won == 2) begin
                D_REQ  = 1'($urandom);
                D_WE   = 1'($urandom);
                D_BE   = 4'($urandom);
                D_ADDR = 30'($urandom);
                D_WD   = $urandom;
            end
            D_INHIBIT = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                 $urandom, 1'($urandom), won);
        end
        I_REQ = 0; D_REQ = 0; D_INHIBIT = 0;
        tick();

`ifdef BUS_TIMEOUT_EN
        I_REQ = 1; I_ADDR = 30'h1234;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("to_mreq", M_REQ, 1);
            tick();
        end
        chk("to_mreq_drop", M_REQ, 0);
        chk("to_iack", I_ACK, 1);
        chk("to_ierr", I_ERR, 1);
        chk("to_irdata", I_RDATA, 0);
        I_REQ = 0;
        tick();
        last_d = 0; mi_rdata = '0;
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
